// File: rtl/button_pkg.sv
// Shared types and 50 MHz default timing constants for the push-button front end.
package button_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HELD,
    RPT_REPEAT
  } rpt_state_t;

  localparam int DEB_10MS         = 500_000;
  localparam int RPT_DELAY_500MS  = 25_000_000;
  localparam int RPT_PERIOD_100MS = 5_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, stability-counter debounce,
// registered press/release pulses and an optional hold-to-repeat FSM.
module button_channel
  import button_pkg::*;
#(
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int STABLE_CYCLES = DEB_10MS,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int REPEAT_DELAY  = RPT_DELAY_500MS,
  parameter int REPEAT_PERIOD = RPT_PERIOD_100MS
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int            DW       = $clog2(STABLE_CYCLES) + 1;
  localparam logic [DW-1:0] DEB_LAST = DW'(STABLE_CYCLES - 1);
  localparam logic          IDLE_PIN = ACTIVE_LOW;

  if (STABLE_CYCLES < 1) begin : g_bad_stable
    $error("button_channel: STABLE_CYCLES must be >= 1");
  end
  if (REPEAT_DELAY < 1) begin : g_bad_delay
    $error("button_channel: REPEAT_DELAY must be >= 1");
  end
  if (REPEAT_PERIOD < 1) begin : g_bad_period
    $error("button_channel: REPEAT_PERIOD must be >= 1");
  end

  logic          sync_p0, sync_p1;
  logic          raw;
  logic [DW-1:0] deb_cnt;
  logic          accept, rise, fall;

  // Stage boundary: asynchronous pin into the clock domain
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= IDLE_PIN;
      sync_p1 <= IDLE_PIN;
    end else begin
      sync_p0 <= btn_in;
      sync_p1 <= sync_p0;
    end
  end

  assign raw    = sync_p1 ^ ACTIVE_LOW;
  assign accept = (raw != level) && (deb_cnt == DEB_LAST);
  assign rise   = accept & raw;
  assign fall   = accept & ~raw;

  // Stage boundary: debounced level and edge pulses update together
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level   <= 1'b0;
      deb_cnt <= '0;
      press   <= 1'b0;
      rel     <= 1'b0;
    end else begin
      press <= rise;
      rel   <= fall;
      if (raw == level) begin
        deb_cnt <= '0;
      end else if (accept) begin
        level   <= raw;
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
    end
  end

  if (REPEAT_EN) begin : g_repeat
    localparam int            RW          = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [RW-1:0] DELAY_LAST  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

    rpt_state_t    state, state_nx;
    logic [RW-1:0] cnt, cnt_nx;
    logic          rpt_nx;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state <= RPT_IDLE;
        cnt   <= '0;
        rpt   <= 1'b0;
      end else begin
        state <= state_nx;
        cnt   <= cnt_nx;
        rpt   <= rpt_nx;
      end
    end

    // The FSM reacts to the same-cycle accept so rpt lands exactly DELAY after the press pulse
    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      if (fall) begin
        state_nx = RPT_IDLE;
        cnt_nx   = '0;
      end else begin
        case (state)
          RPT_IDLE: begin
            if (rise) begin
              state_nx = RPT_HELD;
              cnt_nx   = '0;
            end
          end
          RPT_HELD: begin
            if (cnt == DELAY_LAST) begin
              state_nx = RPT_REPEAT;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + RW'(1);
            end
          end
          RPT_REPEAT: begin
            if (cnt == PERIOD_LAST) cnt_nx = '0;
            else                    cnt_nx = cnt + RW'(1);
          end
          default: begin
            state_nx = RPT_IDLE;
            cnt_nx   = '0;
          end
        endcase
      end
    end

    always_comb begin
      rpt_nx = 1'b0;
      if (!fall) begin
        case (state)
          RPT_HELD:   rpt_nx = (cnt == DELAY_LAST);
          RPT_REPEAT: rpt_nx = (cnt == PERIOD_LAST);
          default:    rpt_nx = 1'b0;
        endcase
      end
    end
  end else begin : g_no_repeat
    assign rpt = 1'b0;
  end

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel push-button conditioner: independent button_channel per input pin.
module button_conditioner
  import button_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int STABLE_CYCLES = DEB_10MS,
  parameter bit REPEAT_EN     = 1'b1,
  parameter int REPEAT_DELAY  = RPT_DELAY_500MS,
  parameter int REPEAT_PERIOD = RPT_PERIOD_100MS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press,
  output logic [CHANNELS-1:0] rel,
  output logic [CHANNELS-1:0] rpt
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    button_channel #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .STABLE_CYCLES(STABLE_CYCLES),
      .REPEAT_EN    (REPEAT_EN),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_channel (
      .clk   (clk),
      .rst   (rst),
      .btn_in(btn_in[i]),
      .level (level[i]),
      .press (press[i]),
      .rel   (rel[i]),
      .rpt   (rpt[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: scripted and random pin activity, event scoreboard
// fed by a window-based reference model, plus direct latency and reset checks.
module tb_button_conditioner;

  localparam int CH = 3;
  localparam int S  = 4;
  localparam int D  = 10;
  localparam int P  = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [CH-1:0] btn_in;
  logic [CH-1:0] level, press, rel, rpt;

  button_conditioner #(
    .CHANNELS(CH), .ACTIVE_LOW(1'b1), .STABLE_CYCLES(S),
    .REPEAT_EN(1'b1), .REPEAT_DELAY(D), .REPEAT_PERIOD(P)
  ) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in),
    .level(level), .press(press), .rel(rel), .rpt(rpt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            cyc;
    logic [CH-1:0] press;
    logic [CH-1:0] rel;
    logic [CH-1:0] rpt;
  } ev_t;

  ev_t           exp_q[$];
  ev_t           ev;
  int            checks = 0;
  int            errors = 0;
  int            cyc    = 0;
  logic [CH-1:0] m_level;
  logic [CH-1:0] pin_q[$];
  logic [S-1:0]  win[CH];
  int            press_cyc[CH];

  // Reference model: raw is the pin two edges late; level flips once the
  // last S raw samples all disagree with it; rpt follows press by D + k*P.
  task automatic model_reset();
    m_level = '0;
    pin_q.delete();
    pin_q.push_back({CH{1'b1}});
    pin_q.push_back({CH{1'b1}});
    for (int c = 0; c < CH; c++) begin
      win[c]       = '0;
      press_cyc[c] = 0;
    end
  endtask

  task automatic model_step();
    logic [CH-1:0] raw, pr, rl, rp;
    raw = ~pin_q.pop_front();
    pin_q.push_back(btn_in);
    cyc = cyc + 1;
    pr = '0; rl = '0; rp = '0;
    for (int c = 0; c < CH; c++) begin
      win[c] = (win[c] << 1) | S'(raw[c]);
      if (win[c] == {S{~m_level[c]}}) begin
        m_level[c] = ~m_level[c];
        if (m_level[c]) begin
          pr[c]        = 1'b1;
          press_cyc[c] = cyc;
        end else begin
          rl[c] = 1'b1;
        end
      end
      if (m_level[c] && !pr[c] && (cyc - press_cyc[c]) >= D &&
          ((cyc - press_cyc[c] - D) % P) == 0)
        rp[c] = 1'b1;
    end
    if ((pr | rl | rp) != '0) exp_q.push_back('{cyc, pr, rl, rp});
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) model_reset();
    else      model_step();
  end

  // Monitor: level every cycle, pulses popped from the scoreboard when the DUT shows one
  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (level !== m_level) begin
        errors++;
        $display("FAIL level cyc=%0d got=%b want=%b", cyc, level, m_level);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        ev = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missed_event cyc=%0d got=none want press=%b rel=%b rpt=%b",
                 ev.cyc, ev.press, ev.rel, ev.rpt);
      end
      if ((press | rel | rpt) != '0) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event cyc=%0d got press=%b rel=%b rpt=%b want=none",
                   cyc, press, rel, rpt);
        end else begin
          ev = exp_q.pop_front();
          if (ev.cyc != cyc || ev.press !== press || ev.rel !== rel || ev.rpt !== rpt) begin
            errors++;
            $display("FAIL event cyc=%0d got press=%b rel=%b rpt=%b want cyc=%0d press=%b rel=%b rpt=%b",
                     cyc, press, rel, rpt, ev.cyc, ev.press, ev.rel, ev.rpt);
          end
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, want);
    end
  endtask

  // Counts falling edges until the chosen pulse (0 press, 1 rel, 2 rpt) is seen on channel ch
  task automatic wait_pulse(input int ch, input int kind, input int limit, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < limit) begin
      @(negedge clk);
      n++;
      case (kind)
        0:       hit = press[ch];
        1:       hit = rel[ch];
        default: hit = rpt[ch];
      endcase
    end
    if (!hit) n = -1;
  endtask

  task automatic check_all_zero(input string name);
    check(name, int'({level, press, rel, rpt}), 0);
  endtask

  int n;
  int hold[CH];

  initial begin
    btn_in = '0;
    model_reset();
    #1;
    check_all_zero("reset_outputs_zero");
    #10;
    btn_in = '1;
    @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_after_reset_level", int'(level), 0);

    // Chatter shorter than the stability window never qualifies
    for (int i = 0; i < 8; i++) begin
      btn_in[0] = ~btn_in[0];
      repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    check("chatter_no_level", int'(level[0]), 0);

    // Press latency, repeat train, release coinciding with a repeat slot
    btn_in[0] = 1'b0;
    wait_pulse(0, 0, 20, n);
    check("press_latency", n, 6);
    check("press_level_same_cycle", int'(level[0]), 1);
    repeat (25) @(negedge clk);
    btn_in[0] = 1'b1;
    wait_pulse(0, 1, 20, n);
    check("rel_latency", n, 6);
    check("rpt_suppressed_on_rel", int'(rpt[0]), 0);
    repeat (10) @(negedge clk);

    // Simultaneous presses, then a short glitch mid-hold
    btn_in[2:1] = 2'b00;
    wait_pulse(1, 0, 20, n);
    check("press1_latency", n, 6);
    check("press2_same_cycle", int'(press[2]), 1);
    repeat (3) @(negedge clk);
    btn_in[2] = 1'b1;
    repeat (3) @(negedge clk);
    btn_in[2] = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_keeps_level2", int'(level[2]), 1);
    btn_in[2:1] = 2'b11;
    repeat (15) @(negedge clk);

    // Asynchronous reset while repeating, then re-qualification of a held button
    btn_in[0] = 1'b0;
    wait_pulse(0, 0, 20, n);
    check("press_before_reset", n, 6);
    repeat (11) @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async_reset_clears");
    @(negedge clk);
    rst = 1'b1;
    wait_pulse(0, 0, 20, n);
    check("press_after_reset", n, 6);
    wait_pulse(0, 2, 20, n);
    check("first_rpt_after_reset", n, D);
    btn_in[0] = 1'b1;
    repeat (15) @(negedge clk);

    // Random activity with occasional long holds and one mid-run reset
    for (int c = 0; c < CH; c++) hold[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          btn_in[c] = 1'($urandom_range(0, 1));
          hold[c]   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(10, 40))
                                                  : int'($urandom_range(1, 7));
        end else begin
          hold[c]--;
        end
      end
      if (i == 1500) begin
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("random_reset_clears");
        @(negedge clk);
        rst = 1'b1;
      end
      @(negedge clk);
    end

    btn_in = '1;
    repeat (20) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
